// File: rtl/t03_fetch_pkg.sv
// Shared types and constants for the t03 instruction fetch stage.
package t03_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/t03_instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time, holds the result for the decoder.
// Optional macro FETCH_MISALIGN_CHK_EN: misaligned redirects are dropped and reported on misalign_err.
module t03_instr_fetch
  import t03_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
  parameter int              TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_err,
  output logic            misalign_err
);

  // The error fires on the WAIT cycle that brings the no-ack count up to TIMEOUT_CYCLES.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  fetch_state_t    state, state_nx;
  logic [XLEN-1:0] pc, pc_nx;
  logic [XLEN-1:0] instr_nx, instr_pc_nx;
  logic            instr_valid_nx;
  logic            flush_pending, flush_pending_nx;
  logic [XLEN-1:0] flush_target, flush_target_nx;
  logic [7:0]      tmo_cnt, tmo_cnt_nx;
  logic            fetch_err_nx;
  logic            misalign_nx;
  logic            redir_take;
  logic [XLEN-1:0] redir_target;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_take   = redirect_en & (redirect_pc[1:0] == 2'b00);
  assign redir_target = redirect_pc;
  assign misalign_nx  = redirect_en & (redirect_pc[1:0] != 2'b00);
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign redir_take      = redirect_en;
  assign redir_target    = {redirect_pc[XLEN-1:2], 2'b00};
  assign misalign_nx     = 1'b0;
`endif

  assign mem_addr = {pc[XLEN-1:2], 2'b00};

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_nx         = state;
    pc_nx            = pc;
    instr_nx         = instr;
    instr_pc_nx      = instr_pc;
    instr_valid_nx   = instr_valid;
    flush_pending_nx = flush_pending;
    flush_target_nx  = flush_target;
    tmo_cnt_nx       = 8'd0;
    fetch_err_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (redir_take) begin
          pc_nx = redir_target;
        end else begin
          pc_nx = pc;
        end
        state_nx = WAIT;
      end
      WAIT: begin
        if (mem_ack) begin
          if (flush_pending || redir_take) begin
            // Stale data: drop it and restart from the newest redirect target.
            pc_nx            = redir_take ? redir_target : flush_target;
            flush_pending_nx = 1'b0;
            state_nx         = IDLE;
          end else begin
            instr_nx       = mem_rdata;
            instr_pc_nx    = pc;
            instr_valid_nx = 1'b1;
            state_nx       = HOLD;
          end
        end else begin
          if (redir_take) begin
            flush_pending_nx = 1'b1;
            flush_target_nx  = redir_target;
          end else begin
            flush_pending_nx = flush_pending;
          end
          if (tmo_cnt == TMO_LAST) begin
            fetch_err_nx = 1'b1;
            tmo_cnt_nx   = 8'd0;
          end else begin
            tmo_cnt_nx = tmo_cnt + 8'd1;
          end
        end
      end
      HOLD: begin
        if (redir_take) begin
          instr_valid_nx = 1'b0;
          pc_nx          = redir_target;
          state_nx       = WAIT;
        end else if (instr_ready) begin
          instr_valid_nx = 1'b0;
          pc_nx          = pc + 32'd4;
          state_nx       = WAIT;
        end else begin
          state_nx = HOLD;
        end
      end
      default: begin
        state_nx       = IDLE;
        instr_valid_nx = 1'b0;
      end
    endcase
  end

  // State and output registers; rst overrides any in-flight fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      mem_req       <= 1'b0;
      instr         <= NOP_INSTR;
      instr_pc      <= 32'h0000_0000;
      instr_valid   <= 1'b0;
      flush_pending <= 1'b0;
      flush_target  <= 32'h0000_0000;
      tmo_cnt       <= 8'd0;
      fetch_err     <= 1'b0;
      misalign_err  <= 1'b0;
    end else begin
      state         <= state_nx;
      pc            <= pc_nx;
      mem_req       <= (state_nx == WAIT);
      instr         <= instr_nx;
      instr_pc      <= instr_pc_nx;
      instr_valid   <= instr_valid_nx;
      flush_pending <= flush_pending_nx;
      flush_target  <= flush_target_nx;
      tmo_cnt       <= tmo_cnt_nx;
      fetch_err     <= fetch_err_nx;
      misalign_err  <= misalign_nx;
    end
  end

endmodule
